// File: rtl/s9io_axil_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x DATA_WIDTH registers with byte strobes,
// read-only status words and per-register commit pulses. Optional: S9IO_REGBANK_DECERR_EN.
module s9io_axil_regbank #(
  parameter int unsigned          NUM_REGS   = 16,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                  aw_done, w_done;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  aw_hs, w_hs, commit, ar_hs;

  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [1:0]            bresp_nxt, rresp_nxt;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_word;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[OFFS-1:0], S_AXI_ARADDR[OFFS-1:0]};

  // Write FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = w_state;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = !aw_done;
        S_AXI_WREADY  = !w_done;
        aw_hs         = S_AXI_AWVALID && !aw_done;
        w_hs          = S_AXI_WVALID && !w_done;
        commit        = (aw_done || aw_hs) && (w_done || w_hs);
        if (commit) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Holding registers let AW and W arrive in either order
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done  <= 1'b1;
        aw_idx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:OFFS];
      end
      if (w_hs) begin
        w_done   <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
    end
  end

  assign wr_idx      = aw_done ? aw_idx_q : S_AXI_AWADDR[ADDR_WIDTH-1:OFFS];
  assign wr_data     = w_done ? w_data_q : S_AXI_WDATA;
  assign wr_strb     = w_done ? w_strb_q : S_AXI_WSTRB;
  assign wr_in_range = 32'(wr_idx) < NUM_REGS;
  assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:OFFS];
  assign rd_in_range = 32'(rd_idx) < NUM_REGS;

`ifdef S9IO_REGBANK_DECERR_EN
  assign bresp_nxt = wr_in_range ? 2'b00 : 2'b11;
  assign rresp_nxt = rd_in_range ? 2'b00 : 2'b11;
`else
  assign bresp_nxt = 2'b00;
  assign rresp_nxt = 2'b00;
`endif

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      wr_sel[i] = commit && (32'(wr_idx) == i) && !RO_MASK[i];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
      bresp_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        for (int unsigned b = 0; b < STRB_W; b++)
          if (wr_sel[i] && wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
      wr_pulse <= wr_sel;
      if (commit) bresp_q <= bresp_nxt;
    end
  end

  assign S_AXI_BRESP = bresp_q;

  always_comb begin
    ctrl_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // Read FSM
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt   = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    ar_hs         = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = 1'b1;
        ar_hs         = S_AXI_ARVALID;
        if (ar_hs) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Out-of-range index matches no entry, leaving the word at zero
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (32'(rd_idx) == i)
        rd_word = RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= '0;
    end else if (ar_hs) begin
      rdata_q <= rd_word;
      rresp_q <= rresp_nxt;
    end
  end

  assign S_AXI_RDATA = rdata_q;
  assign S_AXI_RRESP = rresp_q;

endmodule

// File: tb/tb_s9io_axil_regbank.sv
// Scoreboard bench for s9io_axil_regbank: a RW-only bank and a bank with register 2
// read-only share one AXI stimulus stream; a monitor pops expectations on B/R handshakes.
module tb_s9io_axil_regbank;
  localparam int unsigned NR = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam logic [1:0] OKAY = 2'b00;
`ifdef S9IO_REGBANK_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    awaddr, araddr;
  logic [2:0]       awprot, arprot;
  logic             awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0]    wdata;
  logic [DW/8-1:0]  wstrb;
  logic [NR*DW-1:0] status_in;

  logic             awready, wready, bvalid, arready, rvalid;
  logic [1:0]       bresp, rresp;
  logic [DW-1:0]    rdata;
  logic [NR*DW-1:0] ctrl_out;
  logic [NR-1:0]    wr_pulse;

  logic             awready_ro, wready_ro, bvalid_ro, arready_ro, rvalid_ro;
  logic [1:0]       bresp_ro, rresp_ro;
  logic [DW-1:0]    rdata_ro;
  logic [NR*DW-1:0] ctrl_out_ro;
  logic [NR-1:0]    wr_pulse_ro;

  s9io_axil_regbank #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(16'h0000)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_out(ctrl_out), .status_in(status_in), .wr_pulse(wr_pulse));

  s9io_axil_regbank #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RO_MASK(16'h0004)) dut_ro (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready_ro),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready_ro),
    .S_AXI_BRESP(bresp_ro), .S_AXI_BVALID(bvalid_ro), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_ro),
    .S_AXI_RDATA(rdata_ro), .S_AXI_RRESP(rresp_ro), .S_AXI_RVALID(rvalid_ro), .S_AXI_RREADY(rready),
    .ctrl_out(ctrl_out_ro), .status_in(status_in), .wr_pulse(wr_pulse_ro));

  typedef struct { string nm; logic [31:0] d; logic [31:0] d_ro; logic [1:0] resp; } rd_exp_t;
  typedef struct { string nm; logic [1:0] resp; } wr_exp_t;
  rd_exp_t rq[$];
  wr_exp_t wq[$];

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt[NR];
  int pulse_cnt_ro[NR];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void fail(input string msg);
    n_err++;
    $display("FAIL %s", msg);
  endfunction

  // Monitor: pulse counting and scoreboard pops on B/R handshakes
  always @(negedge clk) begin
    wr_exp_t we;
    rd_exp_t re;
    if (rst_n) begin
      for (int i = 0; i < NR; i++) begin
        if (wr_pulse[i])    pulse_cnt[i]++;
        if (wr_pulse_ro[i]) pulse_cnt_ro[i]++;
      end
      if (bvalid && bready) begin
        if (wq.size() == 0) fail("unexpected_b: BVALID handshake with no write pending");
        else begin
          we = wq.pop_front();
          chk({we.nm, "_bresp"}, 64'(bresp), 64'(we.resp));
          chk({we.nm, "_bresp_ro"}, 64'(bresp_ro), 64'(we.resp));
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) fail("unexpected_r: RVALID handshake with no read pending");
        else begin
          re = rq.pop_front();
          chk({re.nm, "_rdata"}, 64'(rdata), 64'(re.d));
          chk({re.nm, "_rdata_ro"}, 64'(rdata_ro), 64'(re.d_ro));
          chk({re.nm, "_rresp"}, 64'(rresp), 64'(re.resp));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((wq.size() != 0 || rq.size() != 0) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) fail({nm, "_timeout: response not seen within 50 cycles"});
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string nm, input logic [1:0] er);
    bit aw_p = 1'b1, w_p = 1'b1, aw_f, w_f;
    wq.push_back('{nm: nm, resp: er});
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int n = 0; n < 40 && (aw_p || w_p); n++) begin
      @(negedge clk);
      aw_f = aw_p && awready;
      w_f  = w_p && wready;
      step();
      if (aw_f) begin awvalid = 1'b0; aw_p = 1'b0; end
      if (w_f)  begin wvalid  = 1'b0; w_p  = 1'b0; end
    end
    if (aw_p || w_p) begin
      fail({nm, "_handshake: AW/W not accepted within 40 cycles"});
      awvalid = 1'b0; wvalid = 1'b0;
    end
    wait_idle(nm);
  endtask

  task automatic do_read(input logic [7:0] a, input string nm, input logic [31:0] d,
                         input logic [31:0] d_ro, input logic [1:0] er);
    bit done = 1'b0, f;
    rq.push_back('{nm: nm, d: d, d_ro: d_ro, resp: er});
    araddr = a; arvalid = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      f = arready;
      step();
      if (f) begin arvalid = 1'b0; done = 1'b1; end
    end
    if (!done) begin
      fail({nm, "_handshake: AR not accepted within 40 cycles"});
      arvalid = 1'b0;
    end
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int psum;
    for (int i = 0; i < NR; i++) begin pulse_cnt[i] = 0; pulse_cnt_ro[i] = 0; end
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    wdata = '0; wstrb = '0;
    status_in = '0;
    status_in[2*DW +: DW] = 32'hCAFE0002;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(awready), 1);
    chk("rst_wready", 64'(wready), 1);
    chk("rst_arready", 64'(arready), 1);
    chk("rst_bvalid", 64'(bvalid), 0);
    chk("rst_rvalid", 64'(rvalid), 0);
    chk("rst_bresp", 64'(bresp), 0);
    chk("rst_rresp", 64'(rresp), 0);
    chk("rst_rdata", 64'(rdata), 0);
    chk("rst_wr_pulse", 64'(wr_pulse), 0);
    for (int i = 0; i < NR; i++) chk($sformatf("rst_ctrl%0d", i), 64'(ctrl_out[i*DW +: DW]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Basic write/read of four registers
    for (int i = 0; i < 4; i++)
      do_write(8'(i * 4), 32'(i + 1), 4'hF, $sformatf("wr%0d", i), OKAY);
    for (int i = 0; i < 4; i++)
      chk($sformatf("ctrl%0d", i), 64'(ctrl_out[i*DW +: DW]), 64'(i + 1));
    do_read(8'h00, "rd0", 32'd1, 32'd1, OKAY);
    do_read(8'h04, "rd1", 32'd2, 32'd2, OKAY);
    do_read(8'h08, "rd2", 32'd3, 32'hCAFE0002, OKAY);
    do_read(8'h0C, "rd3", 32'd4, 32'd4, OKAY);
    for (int i = 0; i < 4; i++) chk($sformatf("pulse_cnt%0d", i), 64'(pulse_cnt[i]), 1);

    // Byte strobes
    do_write(8'h00, 32'h11223344, 4'hF, "strb_init", OKAY);
    do_write(8'h00, 32'hAABBCCDD, 4'b0101, "strb_wr", OKAY);
    do_read(8'h00, "strb_rd", 32'h11BB33DD, 32'h11BB33DD, OKAY);

    // W three cycles ahead of AW to register 5
    wq.push_back('{nm: "w_first", resp: OKAY});
    awaddr = 8'h14; wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    chk("w_first_wready", 64'(wready), 1);
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("w_first_hold_wready%0d", i), 64'(wready), 0);
      chk($sformatf("w_first_hold_awready%0d", i), 64'(awready), 1);
      chk($sformatf("w_first_hold_bvalid%0d", i), 64'(bvalid), 0);
      step();
    end
    awvalid = 1'b1;
    @(negedge clk);
    chk("w_first_awready", 64'(awready), 1);
    step();
    awvalid = 1'b0;
    @(negedge clk);
    chk("w_first_bvalid", 64'(bvalid), 1);
    chk("w_first_pulse", 64'(wr_pulse[5]), 1);
    chk("w_first_ctrl5", 64'(ctrl_out[5*DW +: DW]), 64'h55);
    step();
    wait_idle("w_first");

    // AW before W to register 6, then BREADY held low
    bready = 1'b0;
    wq.push_back('{nm: "aw_first", resp: OKAY});
    awaddr = 8'h18; wdata = 32'h66; wstrb = 4'hF; awvalid = 1'b1;
    @(negedge clk);
    chk("aw_first_awready", 64'(awready), 1);
    step();
    awvalid = 1'b0;
    @(negedge clk);
    chk("aw_first_awready_drop", 64'(awready), 0);
    chk("aw_first_wready_hold", 64'(wready), 1);
    step();
    wvalid = 1'b1;
    @(negedge clk);
    chk("aw_first_wready", 64'(wready), 1);
    step();
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_bvalid%0d", i), 64'(bvalid), 1);
      chk($sformatf("stall_bresp%0d", i), 64'(bresp), 0);
      chk($sformatf("stall_awready%0d", i), 64'(awready), 0);
      chk($sformatf("stall_wready%0d", i), 64'(wready), 0);
      step();
    end
    bready = 1'b1;
    wait_idle("aw_first");
    chk("aw_first_ctrl6", 64'(ctrl_out[6*DW +: DW]), 64'h66);
    chk("pulse_cnt5", 64'(pulse_cnt[5]), 1);
    chk("pulse_cnt6", 64'(pulse_cnt[6]), 1);

    // Read-only register 2 in dut_ro
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, "ro_write", OKAY);
    chk("ro_pulse_cnt2", 64'(pulse_cnt_ro[2]), 0);
    chk("rw_pulse_cnt2", 64'(pulse_cnt[2]), 2);
    do_read(8'h08, "ro_read", 32'hFFFFFFFF, 32'hCAFE0002, OKAY);

    // Same-edge read and write of register 1 (old 2, new 9)
    rq.push_back('{nm: "same_edge_rd", d: 32'd2, d_ro: 32'd2, resp: OKAY});
    wq.push_back('{nm: "same_edge_wr", resp: OKAY});
    awaddr = 8'h04; araddr = 8'h04; wdata = 32'd9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    chk("same_edge_ready", 64'({awready, wready, arready}), 64'h7);
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_idle("same_edge");
    do_read(8'h04, "after_same_edge", 32'd9, 32'd9, OKAY);

    // Out-of-range accesses
    psum = 0;
    for (int i = 0; i < NR; i++) psum += pulse_cnt[i];
    do_read(8'h40, "oor_read", 32'd0, 32'd0, OOR_RESP);
    do_write(8'h40, 32'hDEADBEEF, 4'hF, "oor_write", OOR_RESP);
    for (int i = 0; i < NR; i++) psum -= pulse_cnt[i];
    chk("oor_no_pulse", 64'(psum), 0);

    // Reset while in W_RESP
    bready = 1'b0;
    wq.push_back('{nm: "rst_mid", resp: OKAY});
    awaddr = 8'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_bvalid_pre", 64'(bvalid), 1);
    chk("rst_mid_ctrl3_pre", 64'(ctrl_out[3*DW +: DW]), 64'h77);
    wq.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_bvalid", 64'(bvalid), 0);
    chk("rst_mid_awready", 64'(awready), 1);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_mid_ctrl%0d", i), 64'(ctrl_out[i*DW +: DW]), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bready = 1'b1;
    step();
    do_read(8'h0C, "post_rst_rd3", 32'd0, 32'd0, OKAY);
    do_read(8'h04, "post_rst_rd1", 32'd0, 32'd0, OKAY);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
